// File: rtl/spi_master_multi_if.sv
// Request/response and SPI pin bundle for spi_master_multi.
// master: the core side issuing frames; slave: the spi_master_multi side.
interface spi_master_multi_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NCS    = 2,
  parameter int unsigned DIV_W  = 8
);
  localparam int unsigned CS_W = (NCS > 1) ? $clog2(NCS) : 1;

  logic              start_in;
  logic              abort_in;
  logic [CS_W-1:0]   cs_sel_in;
  logic              cpol_in;
  logic              cpha_in;
  logic [DIV_W-1:0]  div_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              busy_out;
  logic              done_out;
  logic              err_out;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr_out;
  logic              sclk_out;
  logic              mosi_out;
  logic              miso_in;
  logic [NCS-1:0]    cs_n_out;

  modport master (
    output start_in, abort_in, cs_sel_in, cpol_in, cpha_in, div_in, addr_in, data_in, miso_in,
    input  busy_out, done_out, err_out, data_out, addr_out, sclk_out, mosi_out, cs_n_out
  );

  modport slave (
    input  start_in, abort_in, cs_sel_in, cpol_in, cpha_in, div_in, addr_in, data_in, miso_in,
    output busy_out, done_out, err_out, data_out, addr_out, sclk_out, mosi_out, cs_n_out
  );
endinterface

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: shifts one {addr, data} frame MSB-first, full duplex,
// with per-frame CPOL/CPHA and a programmable SCLK half-period of div+1 clk cycles.
module spi_master_multi #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NCS    = 2,
  parameter int unsigned DIV_W  = 8
) (
  input logic              clk,
  input logic              rst,
  spi_master_multi_if.slave bus
);
  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned EDGES   = 2 * FRAME_W;
  localparam int unsigned EDGE_W  = $clog2(EDGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   phase_q, phase_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [NCS-1:0]     cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               phase_end_c;
  logic               lead_c;
  logic               sample_c;
  logic               shift_c;
  logic               sel_ok_c;
  logic [FRAME_W-1:0] frame_c;

  // Edge classification: the edge about to happen is number edge_q+1 (odd = leading).
  always_comb begin
    phase_end_c = (phase_q == div_q);
    lead_c      = ~edge_q[0];
    sample_c    = phase_end_c & (cpha_q ? ~lead_c : lead_c);
    // CPHA=1 already presents the MSB in SETUP, so the first leading edge does not shift.
    shift_c     = phase_end_c & (cpha_q ? (lead_c & (edge_q != '0)) : ~lead_c);
    sel_ok_c    = (32'(bus.cs_sel_in) < NCS);
    frame_c     = {bus.addr_in, bus.data_in};
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    edge_d  = edge_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_in && !bus.abort_in) begin
          if (sel_ok_c) begin
            state_d = S_SETUP;
            phase_d = '0;
            edge_d  = '0;
            div_d   = bus.div_in;
            cpol_d  = bus.cpol_in;
            cpha_d  = bus.cpha_in;
            tx_d    = frame_c;
            rx_d    = '0;
            cs_n_d  = ~(NCS'(1) << bus.cs_sel_in);
            sclk_d  = bus.cpol_in;
            mosi_d  = frame_c[FRAME_W-1];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (phase_end_c) begin
          state_d = S_XFER;
          phase_d = '0;
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
      S_XFER: begin
        if (phase_end_c) begin
          phase_d = '0;
          edge_d  = edge_q + EDGE_W'(1);
          sclk_d  = ~sclk_q;
          if (sample_c) begin
            rx_d = {rx_q[FRAME_W-2:0], bus.miso_in};
          end
          if (shift_c) begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[FRAME_W-2];
          end
          if (edge_q == EDGE_W'(EDGES - 1)) begin
            state_d = S_HOLD;
          end
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (phase_end_c) begin
          state_d = S_IDLE;
          phase_d = '0;
          cs_n_d  = '1;
          done_d  = 1'b1;
          data_d  = rx_q[DATA_W-1:0];
          addr_d  = rx_q[FRAME_W-1:DATA_W];
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the frame: no done pulse, received fields untouched.
    if ((state_q != S_IDLE) && bus.abort_in) begin
      state_d = S_IDLE;
      phase_d = '0;
      edge_d  = '0;
      cs_n_d  = '1;
      sclk_d  = cpol_q;
      done_d  = 1'b0;
      data_d  = data_q;
      addr_d  = addr_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_n_q  <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.busy_out = busy_q;
  assign bus.done_out = done_q;
  assign bus.err_out  = err_q;
  assign bus.data_out = data_q;
  assign bus.addr_out = addr_q;
  assign bus.sclk_out = sclk_q;
  assign bus.mosi_out = mosi_q;
  assign bus.cs_n_out = cs_n_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi. NCS=3 so that an out-of-range slave
// index (3) is expressible on the 2-bit select.
module tb_spi_master_multi;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NCS    = 3;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CS_W   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_multi_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCS(NCS), .DIV_W(DIV_W)) bus();

  spi_master_multi #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCS(NCS), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int rises     = 0;
  int rise_base = 0;
  int miso_mode = 0;
  int cyc       = 0;
  int at        = 0;
  int dones     = 0;

  // Count SCLK rising edges.
  always @(posedge bus.sclk_out) rises <= rises + 1;

  // MISO source: 0 = loopback from MOSI, 1 = ones for the first four samples then zeros.
  always_comb begin
    bus.miso_in = 1'b0;
    if (miso_mode == 0) bus.miso_in = bus.mosi_out;
    else if (miso_mode == 1) bus.miso_in = ((rises - rise_base) < 4);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Present a frame during cycle 0; returns at the sampling point of cycle 1.
  task automatic launch(input logic [CS_W-1:0] sel, input logic cpol, input logic cpha,
                        input logic [DIV_W-1:0] div, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input bit hold);
    bus.cs_sel_in = sel;
    bus.cpol_in   = cpol;
    bus.cpha_in   = cpha;
    bus.div_in    = div;
    bus.addr_in   = addr;
    bus.data_in   = data;
    bus.abort_in  = 1'b0;
    bus.start_in  = 1'b1;
    cyc = 0;
    step();
    rise_base = rises;
    if (!hold) bus.start_in = 1'b0;
  endtask

  task automatic run_to_done(input int limit, output int done_at);
    done_at = -1;
    while (cyc < limit) begin
      step();
      if (bus.done_out === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.start_in  = 1'b0;
    bus.abort_in  = 1'b0;
    bus.cs_sel_in = '0;
    bus.cpol_in   = 1'b0;
    bus.cpha_in   = 1'b0;
    bus.div_in    = '0;
    bus.addr_in   = '0;
    bus.data_in   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs_n", 32'(bus.cs_n_out), 32'h7);
    check("rst_sclk", 32'(bus.sclk_out), 32'h0);
    check("rst_mosi", 32'(bus.mosi_out), 32'h0);
    check("rst_busy", 32'(bus.busy_out), 32'h0);
    check("rst_done", 32'(bus.done_out), 32'h0);
    check("rst_err",  32'(bus.err_out),  32'h0);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_addr", 32'(bus.addr_out), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, div=0, loopback of 0xA/0x5C
    miso_mode = 0;
    launch(2'd0, 1'b0, 1'b0, 8'd0, 4'hA, 8'h5C, 1'b0);
    check("t1_busy_setup", 32'(bus.busy_out), 32'h1);
    check("t1_cs_setup",   32'(bus.cs_n_out), 32'h6);
    check("t1_sclk_setup", 32'(bus.sclk_out), 32'h0);
    check("t1_mosi_msb",   32'(bus.mosi_out), 32'h1);
    run_to_done(60, at);
    check("t1_latency", 32'(at), 32'd27);
    check("t1_data",    32'(bus.data_out), 32'h5C);
    check("t1_addr",    32'(bus.addr_out), 32'hA);
    check("t1_rises",   32'(rises - rise_base), 32'd12);
    check("t1_cs_idle", 32'(bus.cs_n_out), 32'h7);
    check("t1_busy_idle", 32'(bus.busy_out), 32'h0);
    step();
    check("t1_done_pulse", 32'(bus.done_out), 32'h0);

    // Abort at cycle 10
    launch(2'd0, 1'b0, 1'b0, 8'd0, 4'h3, 8'h33, 1'b0);
    while (cyc < 10) step();
    bus.abort_in = 1'b1;
    step();
    bus.abort_in = 1'b0;
    check("ab_cycle", 32'(cyc), 32'd11);
    check("ab_busy",  32'(bus.busy_out), 32'h0);
    check("ab_cs_n",  32'(bus.cs_n_out), 32'h7);
    check("ab_sclk",  32'(bus.sclk_out), 32'h0);
    check("ab_done",  32'(bus.done_out), 32'h0);
    check("ab_data",  32'(bus.data_out), 32'h5C);
    dones = 0;
    repeat (30) begin
      step();
      if (bus.done_out === 1'b1) dones++;
    end
    check("ab_no_done", 32'(dones), 32'd0);
    check("ab_addr",    32'(bus.addr_out), 32'hA);

    // Mode 3, div=3, MISO shifts in 0xF00
    miso_mode = 1;
    launch(2'd0, 1'b1, 1'b1, 8'd3, 4'h2, 8'h96, 1'b0);
    check("t2_sclk_idle_hi", 32'(bus.sclk_out), 32'h1);
    check("t2_mosi_msb",     32'(bus.mosi_out), 32'h0);
    while (cyc < 8) step();
    check("t2_sclk_c8",  32'(bus.sclk_out), 32'h1);
    step();
    check("t2_sclk_c9",  32'(bus.sclk_out), 32'h0);
    while (cyc < 12) step();
    check("t2_sclk_c12", 32'(bus.sclk_out), 32'h0);
    step();
    check("t2_sclk_c13", 32'(bus.sclk_out), 32'h1);
    run_to_done(200, at);
    check("t2_latency", 32'(at), 32'd105);
    check("t2_addr",    32'(bus.addr_out), 32'hF);
    check("t2_data",    32'(bus.data_out), 32'h00);
    check("t2_sclk_end", 32'(bus.sclk_out), 32'h1);
    miso_mode = 0;
    step();

    // Slave 1 select, then illegal index 3
    launch(2'd1, 1'b0, 1'b0, 8'd0, 4'h5, 8'hA1, 1'b0);
    check("t3_cs_sel1", 32'(bus.cs_n_out), 32'h5);
    run_to_done(60, at);
    check("t3_latency", 32'(at), 32'd27);
    check("t3_data",    32'(bus.data_out), 32'hA1);
    check("t3_addr",    32'(bus.addr_out), 32'h5);
    step();
    launch(2'd3, 1'b0, 1'b0, 8'd0, 4'h1, 8'h11, 1'b0);
    check("t3_err_pulse", 32'(bus.err_out),  32'h1);
    check("t3_err_busy",  32'(bus.busy_out), 32'h0);
    check("t3_err_cs",    32'(bus.cs_n_out), 32'h7);
    step();
    check("t3_err_once",  32'(bus.err_out),  32'h0);
    check("t3_err_busy2", 32'(bus.busy_out), 32'h0);

    // Back-to-back with start held high
    launch(2'd2, 1'b0, 1'b0, 8'd0, 4'hC, 8'h3E, 1'b1);
    run_to_done(60, at);
    check("t6_first_done", 32'(at), 32'd27);
    check("t6_data1", 32'(bus.data_out), 32'h3E);
    step();
    check("t6_restart_busy", 32'(bus.busy_out), 32'h1);
    check("t6_restart_cs",   32'(bus.cs_n_out), 32'h3);
    bus.start_in = 1'b0;
    run_to_done(100, at);
    check("t6_second_done", 32'(at), 32'd54);
    check("t6_addr2", 32'(bus.addr_out), 32'hC);
    step();
    check("t6_stop_busy", 32'(bus.busy_out), 32'h0);

    // Asynchronous reset mid-XFER, then a clean frame
    launch(2'd0, 1'b0, 1'b0, 8'd0, 4'h6, 8'h99, 1'b0);
    while (cyc < 11) step();
    check("t5_pre_sclk", 32'(bus.sclk_out), 32'h1);
    rst = 1'b0;
    #1;
    check("t5_cs_n", 32'(bus.cs_n_out), 32'h7);
    check("t5_sclk", 32'(bus.sclk_out), 32'h0);
    check("t5_busy", 32'(bus.busy_out), 32'h0);
    check("t5_data", 32'(bus.data_out), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(2'd0, 1'b0, 1'b0, 8'd0, 4'h6, 8'h99, 1'b0);
    run_to_done(60, at);
    check("t5_latency", 32'(at), 32'd27);
    check("t5_data2", 32'(bus.data_out), 32'h99);
    check("t5_addr2", 32'(bus.addr_out), 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
